// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: oversampled async rx line to parallel words.
// Ports: clk, reset (sync, active-high), rx in; data_out/data_valid/
//   data_ready handshake; parity_err, frame_err, overrun_err, timeout, busy.
module serial_frame_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY_MODE  = 0,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 timeout,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int IW    = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] BLST = IDX_W'(DATA_BITS - 1);
  localparam logic [IW-1:0]    TO   = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]    TO_M = IW'(IDLE_TIMEOUT - 1);
  localparam logic             ODD  = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_n;

  logic rx_m, rx_s, rx_p;
  logic start_edge, samp, stop_samp;

  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [IW-1:0]        idle_cnt;

  // rx_p is the previous rx_s, used for falling-edge start detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign start_edge = rx_p & ~rx_s;

  // start bit is sampled at its mid-point, later bits one bit-time apart
  always_comb begin
    samp = 1'b0;
    case (state)
      S_START:                  samp = (cnt == MID);
      S_DATA, S_PARITY, S_STOP: samp = (cnt == LAST);
      default:                  samp = 1'b0;
    endcase
  end

  assign stop_samp = (state == S_STOP) && samp;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (start_edge) state_n = S_START;
      S_START:
        if (samp) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (samp && bit_idx == BLST)
          state_n = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
      S_PARITY:
        if (samp) state_n = S_STOP;
      S_STOP:
        if (samp) state_n = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:
        if (rx_s) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = !(state == S_IDLE || state == S_BREAK);
  end

  // bit-time counter restarts at every sample and state change
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (!busy || samp || state_n != state)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      if (state == S_START) begin
        bit_idx <= '0;
        par_q   <= 1'b0;
      end
      if (state == S_DATA && samp)
        bit_idx <= bit_idx + 1'b1;
      for (int k = 0; k < DATA_BITS; k++)
        if (state == S_DATA && samp && bit_idx == IDX_W'(k))
          shreg[k] <= rx_s;
      if (state == S_PARITY && samp)
        par_q <= (^shreg) ^ rx_s ^ ODD;
    end
  end

  // a held word is never overwritten; a frame finishing onto it is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (stop_samp && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        parity_err <= par_q;
        frame_err  <= ~rx_s;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (stop_samp && data_valid && !data_ready)
        overrun_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b1;
    end else begin
      if (state != S_IDLE || !rx_s)
        idle_cnt <= '0;
      else if (idle_cnt != TO)
        idle_cnt <= idle_cnt + 1'b1;
      if (state == S_IDLE && start_edge)
        timeout <= 1'b0;
      else if (state == S_IDLE && rx_s && idle_cnt >= TO_M)
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (4 clk/bit, 8 bits, even parity).
// Each task drives one scenario and checks hand-computed results inline.
module tb_serial_frame_receiver;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err;
  logic       overrun_err, timeout, busy;

  int checks = 0;
  int passed = 0;

  int dv_cyc = 0;
  int ov_cyc = 0;
  int bz_cyc = 0;
  logic [7:0] l_data = '0;
  logic       l_perr = 1'b0;
  logic       l_ferr = 1'b0;

  serial_frame_receiver #(
    .DATA_BITS(8),
    .CLKS_PER_BIT(CPB),
    .PARITY_MODE(1),
    .IDLE_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cyc = dv_cyc + 1;
      l_data = data_out;
      l_perr = parity_err;
      l_ferr = frame_err;
    end
    if (overrun_err) ov_cyc = ov_cyc + 1;
    if (busy) bz_cyc = bz_cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed = passed + 1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_tail(input logic [7:0] d, input logic p,
                           input logic s);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    drive_bit(1'b0);
    send_tail(d, p, s);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks = checks + 1;
    if ({data_out, data_valid, parity_err, frame_err,
         overrun_err, busy, timeout} !== 14'h0001)
      $display("FAIL reset_state: got %h expected 0001",
               {data_out, data_valid, parity_err, frame_err,
                overrun_err, busy, timeout});
    else
      passed = passed + 1;
  endtask

  task automatic test_timeout;
    int lows;
    lows = 0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      if (!timeout) lows++;
    end
    checks = checks + 1;
    if (lows !== 0)
      $display("FAIL timeout_hold: got %0d low cycles expected 0", lows);
    else
      passed = passed + 1;
    drive_bit(1'b0);
    chk("timeout_start", timeout, 0);
    send_tail(8'h0F, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("timeout_19", timeout, 0);
    @(posedge clk);
    #1;
    chk("timeout_20", timeout, 1);
  endtask

  task automatic test_good_frame;
    int dv0;
    data_ready = 1'b1;
    dv0 = dv_cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("good_dv_cycles", dv_cyc - dv0, 1);
    chk("good_data", l_data, 8'hA5);
    chk("good_errs", {l_perr, l_ferr}, 0);
  endtask

  task automatic test_parity_err;
    int dv0;
    dv0 = dv_cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    chk("perr_dv_cycles", dv_cyc - dv0, 1);
    chk("perr_data", l_data, 8'hA5);
    chk("perr_flags", {l_perr, l_ferr}, 2);
  endtask

  task automatic test_frame_err;
    int dv0, bz0;
    dv0 = dv_cyc;
    send_frame(8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bz0 = bz_cyc;
    repeat (12) @(posedge clk);
    #1;
    chk("ferr_busy_break", busy, 0);
    idle(8);
    chk("ferr_busy_cycles", bz_cyc - bz0, 0);
    chk("ferr_dv_cycles", dv_cyc - dv0, 1);
    chk("ferr_flags", {l_perr, l_ferr}, 1);
    chk("ferr_data", l_data, 8'hA5);
  endtask

  task automatic test_glitch;
    int dv0, bz0;
    dv0 = dv_cyc;
    bz0 = bz_cyc;
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    chk("glitch_dv", dv_cyc - dv0, 0);
    chk("glitch_busy_cycles", bz_cyc - bz0, 2);
    chk("glitch_busy_end", busy, 0);
  endtask

  task automatic test_overrun;
    int ov0;
    data_ready = 1'b0;
    ov0 = ov_cyc;
    send_frame(8'h11, 1'b0, 1'b1);
    idle(4);
    chk("ovr_first_dv", data_valid, 1);
    chk("ovr_first_data", data_out, 8'h11);
    chk("ovr_first_none", ov_cyc - ov0, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(4);
    chk("ovr_pulse", ov_cyc - ov0, 1);
    chk("ovr_held_data", data_out, 8'h11);
    chk("ovr_held_dv", data_valid, 1);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_dv_clear", data_valid, 0);
  endtask

  task automatic test_back_to_back;
    int dv0;
    data_ready = 1'b1;
    dv0 = dv_cyc;
    send_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(4);
    chk("b2b_dv_cycles", dv_cyc - dv0, 2);
    chk("b2b_data", l_data, 8'h7E);
    chk("b2b_perr", l_perr, 0);
  endtask

  task automatic test_reset_midframe;
    int dv0;
    logic [7:0] d;
    d = 8'h3C;
    dv0 = dv_cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstmid_busy", busy, 0);
    idle(6);
    chk("rstmid_no_dv", dv_cyc - dv0, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(4);
    chk("rstmid_next_dv", dv_cyc - dv0, 1);
    chk("rstmid_next_data", l_data, 8'h5A);
    chk("rstmid_next_errs", {l_perr, l_ferr}, 0);
  endtask

  initial begin
    test_reset;
    test_timeout;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_glitch;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 2, clk cycles per bit, even, range 2..1024.
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity bit: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 20, consecutive high rx cycles in IDLE that raise timeout.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line, idle high, LSB first.
REQ-008 SHALL have port data_out, output, DATA_BITS, last received word.
REQ-009 SHALL have port data_valid, output, 1, data_out holds an unconsumed word.
REQ-010 SHALL have port data_ready, input, 1, consumer accepts word when high with data_valid.
REQ-011 SHALL have port parity_err, output, 1, parity mismatch for the word in data_out.
REQ-012 SHALL have port frame_err, output, 1, stop bit sampled low for the word in data_out.
REQ-013 SHALL have port overrun_err, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port timeout, output, 1, line idle for IDLE_TIMEOUT cycles.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE and BREAK.

Function
REQ-016 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK; PARITY skipped when PARITY_MODE=0.
REQ-018 IDLE: rx_s low with previous rx_s high -> START; bit counter cleared to 0.
REQ-019 START: sample at bit counter = CLKS_PER_BIT/2-1; rx_s high -> IDLE, no output (glitch reject); low -> DATA.
REQ-020 DATA: sample every CLKS_PER_BIT cycles after the start mid-point; bit k stored to shift-register bit k; after DATA_BITS samples -> PARITY or STOP.
REQ-021 PARITY: sample one bit; parity_err value = XOR(data, sampled bit) for even, its inverse for odd.
REQ-022 STOP: sample one bit; frame_err value = NOT sampled bit; stop high -> IDLE, stop low -> BREAK.
REQ-023 BREAK: wait for rx_s high, then -> IDLE; no start detection while in BREAK.
REQ-024 At stop sample, if data_valid low or (data_valid and data_ready) same cycle: data_out, parity_err, frame_err load next edge, data_valid set.
REQ-025 At stop sample, if data_valid high and data_ready low: held word kept unchanged, overrun_err pulsed one cycle, new word discarded.
REQ-026 data_valid SHALL clear the edge after a cycle with data_valid and data_ready both high, unless REQ-024 reloads it that cycle.
REQ-027 parity_err and frame_err SHALL be valid only while data_valid is high and change only with data_out.
REQ-028 data_valid SHALL rise exactly one clk after the stop-bit sample cycle.
REQ-029 Idle counter SHALL count cycles with rx_s high in IDLE, saturate at IDLE_TIMEOUT, clear on rx_s low or leaving IDLE.
REQ-030 timeout SHALL set when idle counter reaches IDLE_TIMEOUT and clear on the START transition.
REQ-031 Bit counter width SHALL be clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-032 reset SHALL force state IDLE, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun_err 0, busy 0, timeout 1, counters 0, synchronizer flops 1.
REQ-033 reset mid-frame SHALL abort the frame with no data_valid; reset has priority over all events.

Verification
REQ-034 CLKS_PER_BIT=4, DATA_BITS=8, PARITY_MODE=1, frame 0xA5 parity 0 stop 1, data_ready=1 -> data_out=0xA5, data_valid one cycle, no errors.
REQ-035 Same config, 0xA5 with parity bit 1 -> data_out=0xA5, parity_err=1; stop bit 0 -> frame_err=1, busy stays 0 in BREAK until rx high.
REQ-036 rx low 1 bit-time/4, then high -> no data_valid, state back to IDLE, busy high only during START.
REQ-037 data_ready=0, frames 0x11 then 0x22 -> data_out stays 0x11, overrun_err pulse at second stop sample; raise data_ready -> data_valid clears.
REQ-038 After reset, rx high 19 cycles -> timeout stays 1 from reset; start bit then 20 high cycles after frame -> timeout 0 at START, 1 at 20th idle cycle.
REQ-039 reset asserted during DATA bit 3 of frame 0x3C -> no data_valid, next frame 0x5A received correctly.
